// File: rtl/local_ram_fifo_ctrl.sv
// local_ram_fifo_ctrl: packs a byte stream into 3-byte words held in an
// external byte-lane RAM and replays them as a word stream.
// Ports: clk, rst (async, active-high); s_valid/s_ready/s_data/s_last byte
// input; m_valid/m_ready/m_data/m_bytes word output; level = stored words;
// ram_din/ram_we/ram_wraddr write port, ram_rdaddr/ram_dout read port.
// Option: LOCAL_RAM_PARTIAL_FLUSH_EN lets s_last commit a 1- or 2-byte word.
module local_ram_fifo_ctrl #(
  parameter int AddrWidth = 6,
  parameter int ByteWidth = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [7:0]             s_data,
  input  logic                   s_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [23:0]            m_data,
  output logic [1:0]             m_bytes,
  output logic [AddrWidth:0]     level,
  output logic [7:0]             ram_din,
  output logic [2:0]             ram_we,
  output logic [AddrWidth-1:0]   ram_wraddr,
  output logic [AddrWidth-1:0]   ram_rdaddr,
  input  logic [ByteWidth*8-1:0] ram_dout
);

  localparam int Depth = 1 << AddrWidth;
  localparam logic [AddrWidth:0] Full = (AddrWidth+1)'(Depth);
  localparam logic [AddrWidth:0] One = (AddrWidth+1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    VALID
  } state_t;

  state_t state, state_n;

  logic [1:0]           lane;
  logic [AddrWidth-1:0] wr_ptr;
  logic [AddrWidth-1:0] rd_ptr;
  logic                 acc;
  logic                 flush;
  logic                 commit;
  logic                 pop;
  logic [1:0]           rd_cnt;
  logic [23:0]          m_data_n;
  logic                 unused_bits;

  assign unused_bits = ^{ram_dout, s_last};

`ifdef LOCAL_RAM_PARTIAL_FLUSH_EN
  // Byte count of each committed word, indexed like the RAM.
  logic [1:0] cnt_mem [Depth];

  always_ff @(posedge clk) begin
    if (commit) cnt_mem[wr_ptr] <= lane + 2'd1;
  end

  assign flush  = s_last;
  assign rd_cnt = cnt_mem[rd_ptr];
`else
  assign flush  = 1'b0;
  assign rd_cnt = 2'd3;
`endif

  // s_ready is forced low while reset is held.
  assign s_ready = !rst && (level != Full);
  assign acc     = s_valid && s_ready;
  assign commit  = acc && ((lane == 2'd2) || flush);
  assign pop     = m_valid && m_ready;

  assign ram_din    = s_data;
  assign ram_we     = acc ? (3'b001 << lane) : 3'b000;
  assign ram_wraddr = wr_ptr;
  assign ram_rdaddr = rd_ptr;
  assign m_valid    = (state == VALID);

  // Lanes beyond the stored count may hold stale RAM bytes.
  always_comb begin
    m_data_n = {16'h0000, ram_dout[7:0]};
    if (rd_cnt > 2'd1) m_data_n[15:8] = ram_dout[15:8];
    if (rd_cnt > 2'd2) m_data_n[23:16] = ram_dout[23:16];
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (level != '0) state_n = FETCH;
      FETCH:   state_n = VALID;
      VALID:   if (m_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      lane    <= 2'd0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      m_data  <= '0;
      m_bytes <= 2'd0;
    end else begin
      state <= state_n;
      if (commit) begin
        lane   <= 2'd0;
        wr_ptr <= wr_ptr + 1'b1;
      end else if (acc) begin
        lane <= lane + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (commit && !pop) level <= level + One;
      else if (!commit && pop) level <= level - One;
      // ram_dout now reflects rd_ptr presented during IDLE.
      if (state == FETCH) begin
        m_data  <= m_data_n;
        m_bytes <= rd_cnt;
      end
    end
  end

endmodule

// File: doc/local_ram_fifo_ctrl.md
LOCAL_RAM_FIFO_CTRL -- requirements
Module: local_ram_fifo_ctrl

Interface
REQ-001 Parameter: AddrWidth, default 6, RAM word address width; DEPTH = 2**AddrWidth words.
REQ-002 Parameter: ByteWidth, default 12, RAM read-word width in bytes; only bytes 0..2 are used.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: s_valid  input  1  write-side byte valid.
REQ-006 Port: s_ready  output  1  write-side byte accepted when high together with s_valid.
REQ-007 Port: s_data  input  8  write-side byte.
REQ-008 Port: s_last  input  1  marks the final byte of a packet; flushes a partial word.
REQ-009 Port: m_valid  output  1  read-side word valid.
REQ-010 Port: m_ready  input  1  read-side consumer ready.
REQ-011 Port: m_data  output  24  packed word; byte 0 in [7:0].
REQ-012 Port: m_bytes  output  2  number of valid bytes in m_data (1..3).
REQ-013 Port: level  output  AddrWidth+1  number of committed words stored and not yet popped.
REQ-014 Port: ram_din  output  8  byte to the RAM.
REQ-015 Port: ram_we  output  3  per-lane byte write enables to the RAM.
REQ-016 Port: ram_wraddr  output  AddrWidth  RAM write address.
REQ-017 Port: ram_rdaddr  output  AddrWidth  RAM read address.
REQ-018 Port: ram_dout  input  ByteWidth*8  RAM registered read data, valid one cycle after ram_rdaddr.

Function
REQ-019 A byte is accepted when s_valid and s_ready are both high; s_ready = (level != DEPTH).
REQ-020 A lane counter (0,1,2) selects the byte lane for writes. Combinationally: ram_we = onehot(lane) when a byte is accepted, else 0; ram_din = s_data; ram_wraddr = wr_ptr.
REQ-021 When a byte is accepted and lane is not 2 and no flush applies, lane increments by 1.
REQ-022 A word commits when a byte is accepted on lane 2, or when it is accepted with s_last high (see REQ-033). On commit: the byte count (lane+1) is stored in a DEPTH x 2 side array at wr_ptr, wr_ptr increments modulo DEPTH, level increments, and lane returns to 0.
REQ-023 Read FSM states: IDLE, FETCH, VALID. ram_rdaddr = rd_ptr at all times.
REQ-024 IDLE goes to FETCH when level != 0. FETCH always goes to VALID, capturing ram_dout[23:0] into m_data and the side-array count into m_bytes. VALID goes to IDLE when m_ready is high.
REQ-025 m_valid = (state == VALID). A pop is m_valid && m_ready; on a pop, rd_ptr increments modulo DEPTH and level decrements.
REQ-026 Latency: m_valid rises exactly 2 cycles after the commit edge of a word written into an empty store. There is no read-during-write hazard, because the reader only addresses committed words.
REQ-027 Byte lanes at or above m_bytes shall read as zero in m_data.
REQ-028 A commit and a pop in the same cycle leave level unchanged.
REQ-029 When full (level == DEPTH), s_ready is low and no RAM write occurs; a pop in that cycle raises s_ready on the next cycle.
REQ-030 wr_ptr and rd_ptr wrap from DEPTH-1 to 0 with no data loss.

Reset
REQ-031 While rst is high: lane=0, wr_ptr=0, rd_ptr=0, level=0, state=IDLE, m_valid=0, m_data=0, m_bytes=0, ram_we=0, s_ready=0.
REQ-032 Assertion of rst mid-packet discards the uncommitted partial word and all stored words; RAM contents are not cleared.

Configuration
REQ-033 With macro LOCAL_RAM_PARTIAL_FLUSH_EN defined, s_last on lane 0 or lane 1 commits a partial word with m_bytes = lane+1. Without the macro, s_last is ignored, only lane 2 commits, and m_bytes is constant 3.

Verification
REQ-034 Write bytes 0x11,0x22,0x33 on consecutive cycles with m_ready=1 -> ram_we = 001,010,100; m_data=0x332211 and m_bytes=3, with m_valid high 2 cycles after the third byte.
REQ-035 With the macro defined, write 0xAA then 0xBB with s_last on the second byte -> m_data=0x00BBAA, m_bytes=2; the next byte lands on lane 0 at the next address.
REQ-036 Hold m_ready=0 and write 3*DEPTH bytes -> level=DEPTH and s_ready=0; a further byte produces no ram_we; one pop -> s_ready=1 on the next cycle.
REQ-037 Stream 3*(DEPTH+5) bytes with m_ready=1 -> every word pops in order, confirming pointer wrap-around with no loss or duplication.
REQ-038 Assert rst after one byte of a word, then write 3 bytes -> level=1 and m_data contains only the 3 post-reset bytes.
REQ-039 Force a commit and a pop in the same cycle -> level unchanged and the data order is preserved.
